// File: rtl/bit_place_scheduler.sv
// bit_place_scheduler: round-robin reader of bit-place FIFO lanes producing weight << place entries
//   CLK/RSTN       clock, synchronous active-high reset
//   LaneReadReady  per-lane FIFO non-empty; LaneReadEnable one-cycle pop of the granted lane
//   LaneReadData   per-lane place (valid cycle after pop); LaneWeight per-lane weight
//   OutValid/OutReady handshake carrying OutLane, OutPlace, OutProduct
//   GrantCount     per-lane 16-bit handshake counters, present only with BIT_PLACE_SCHEDULER_STATS_EN
module bit_place_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W = 2,
  parameter int PLACE_W = 3,
  parameter int WEIGHT_W = 8,
  localparam int PROD_W = WEIGHT_W + 2**PLACE_W
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [NUM_LANES-1:0]          LaneReadReady,
  output logic [NUM_LANES-1:0]          LaneReadEnable,
  input  logic [NUM_LANES*PLACE_W-1:0]  LaneReadData,
  input  logic [NUM_LANES*WEIGHT_W-1:0] LaneWeight,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [LANE_W-1:0]             OutLane,
  output logic [PLACE_W-1:0]            OutPlace,
  output logic [PROD_W-1:0]             OutProduct
`ifdef BIT_PLACE_SCHEDULER_STATS_EN
  ,
  output logic [NUM_LANES*16-1:0]       GrantCount
`endif
);
  typedef enum logic [1:0] {S_ARB = 2'd0, S_FETCH = 2'd1, S_OUT = 2'd2} state_t;
  state_t state_q, state_d;
  logic [LANE_W-1:0] grant_q, grant_d, last_q, last_d, lane_q, lane_d, pick;
  logic [PLACE_W-1:0] place_q, place_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [WEIGHT_W-1:0] weight;
  logic valid_q, valid_d, found, hs;
  // Search starts one past the last delivered lane so priority rotates
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      if (!found && LaneReadReady[(int'(last_q) + k) % NUM_LANES]) begin
        found = 1'b1;
        pick = LANE_W'((int'(last_q) + k) % NUM_LANES);
      end
    end
  end
  assign weight = LaneWeight[grant_q*WEIGHT_W +: WEIGHT_W];
  assign hs = (state_q == S_OUT) && OutReady;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    valid_d = valid_q;
    lane_d = lane_q;
    place_d = place_q;
    prod_d = prod_q;
    LaneReadEnable = '0;
    case (state_q)
      S_ARB: if (found) begin
        LaneReadEnable = NUM_LANES'(1) << pick;
        grant_d = pick;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        lane_d = grant_q;
        place_d = LaneReadData[grant_q*PLACE_W +: PLACE_W];
        prod_d = PROD_W'(weight) << LaneReadData[grant_q*PLACE_W +: PLACE_W];
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: if (OutReady) begin
        valid_d = 1'b0;
        last_d = grant_q;
        state_d = S_ARB;
      end
      default: state_d = S_ARB;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q <= S_ARB;
      grant_q <= '0;
      last_q <= LANE_W'(NUM_LANES - 1);
      valid_q <= 1'b0;
      lane_q <= '0;
      place_q <= '0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      valid_q <= valid_d;
      lane_q <= lane_d;
      place_q <= place_d;
      prod_q <= prod_d;
    end
  end
  assign OutValid = valid_q;
  assign OutLane = lane_q;
  assign OutPlace = place_q;
  assign OutProduct = prod_q;
`ifdef BIT_PLACE_SCHEDULER_STATS_EN
  logic [15:0] cnt_q [NUM_LANES];
  always_ff @(posedge CLK) begin
    if (RSTN) for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
    else if (hs) cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
  end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_cnt
    assign GrantCount[g*16 +: 16] = cnt_q[g];
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif
endmodule

// File: tb/tb_bit_place_scheduler.sv
// tb_bit_place_scheduler: directed checks of arbitration, fetch latency, backpressure and reset
module tb_bit_place_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] rdy = '0;
  logic [3:0] en;
  logic [11:0] data = '0;
  logic [31:0] wgt = '0;
  logic ovalid, ordy = 1'b1;
  logic [1:0] olane;
  logic [2:0] oplace;
  logic [15:0] oprod;
  int passed = 0;
  int total = 0;
  bit_place_scheduler dut (
    .CLK(clk), .RSTN(rst), .LaneReadReady(rdy), .LaneReadEnable(en),
    .LaneReadData(data), .LaneWeight(wgt), .OutValid(ovalid), .OutReady(ordy),
    .OutLane(olane), .OutPlace(oplace), .OutProduct(oprod)
`ifdef BIT_PLACE_SCHEDULER_STATS_EN
    , .GrantCount()
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic pos();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  initial begin
    pos();
    pos();
    neg();
    chk("rst_valid", ovalid, 0);
    chk("rst_lane", olane, 0);
    chk("rst_place", oplace, 0);
    chk("rst_prod", oprod, 0);
    chk("rst_en", en, 0);
    chk("rst_state", dut.state_q, 0);
    pos();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      neg();
      chk("idle_en", en, 0);
      chk("idle_valid", ovalid, 0);
      chk("idle_state", dut.state_q, 0);
      pos();
    end
    // lane 2 alone: place 5, weight 0x81
    data = 12'(5) << 6;
    wgt = 32'h81 << 16;
    rdy = 4'b0100;
    neg();
    chk("l2_grant_en", en, 4'b0100);
    pos();
    rdy = 4'b0000;
    neg();
    chk("l2_fetch_en", en, 0);
    chk("l2_fetch_valid", ovalid, 0);
    pos();
    neg();
    chk("l2_valid", ovalid, 1);
    chk("l2_lane", olane, 2);
    chk("l2_place", oplace, 5);
    chk("l2_prod", oprod, 16'h1020);
    pos();
    neg();
    chk("l2_done_valid", ovalid, 0);
    // fresh reset, then all lanes ready: lane i has place i+1, weight 0x10+i
    rst = 1'b1;
    pos();
    rst = 1'b0;
    data = {3'd4, 3'd3, 3'd2, 3'd1};
    wgt = 32'h13121110;
    rdy = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      neg();
      chk("rr_grant", en, 4'b0001 << (g % 4));
      pos();
      neg();
      chk("rr_fetch_en", en, 0);
      pos();
      neg();
      chk("rr_valid", ovalid, 1);
      chk("rr_lane", olane, g % 4);
      chk("rr_place", oplace, (g % 4) + 1);
      chk("rr_prod", oprod, 16'(16 + g % 4) << ((g % 4) + 1));
      chk("rr_out_en", en, 0);
      pos();
    end
    // backpressure on lane 0 (place 1, weight 0x10 -> 0x20)
    ordy = 1'b0;
    neg();
    chk("bp_grant", en, 4'b0001);
    pos();
    pos();
    rdy = 4'b0010;
    data = {3'd4, 3'd3, 3'd2, 3'd7};
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_valid", ovalid, 1);
      chk("bp_lane", olane, 0);
      chk("bp_place", oplace, 1);
      chk("bp_prod", oprod, 16'h0020);
      chk("bp_en", en, 0);
      pos();
    end
    ordy = 1'b1;
    pos();
    neg();
    chk("bp_release_valid", ovalid, 0);
    chk("bp_next_grant", en, 4'b0010);
    // reset mid-transaction in S_OUT
    ordy = 1'b0;
    pos();
    pos();
    neg();
    chk("mid_valid", ovalid, 1);
    chk("mid_lane", olane, 1);
    rst = 1'b1;
    pos();
    rst = 1'b0;
    rdy = 4'b1111;
    neg();
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_state", dut.state_q, 0);
    chk("mid_rst_grant", en, 4'b0001);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bit_place_scheduler.md
BIT_PLACE_SCHEDULER -- requirements
Module: bit_place_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 4: number of bit-place FIFO lanes arbitrated.
REQ-002 Parameter LANE_W, default 2: lane-index width, equal to clog2(NUM_LANES).
REQ-003 Parameter PLACE_W, default 3: bit-place width.
REQ-004 Parameter WEIGHT_W, default 8: per-lane weight width.
REQ-005 CLK  in  1: single clock; all logic SHALL be posedge CLK.
REQ-006 RSTN  in  1: synchronous, active-high reset (asserted = 1).
REQ-007 LaneReadReady  in  NUM_LANES: per-lane bit-place FIFO rd_rdy (non-empty).
REQ-008 LaneReadEnable  out  NUM_LANES: per-lane FIFO rd_en; read data is valid the cycle after it.
REQ-009 LaneReadData  in  NUM_LANES*PLACE_W: per-lane FIFO rd_do; lane i occupies bits [i*PLACE_W +: PLACE_W].
REQ-010 LaneWeight  in  NUM_LANES*WEIGHT_W: per-lane weight, sampled at the capture cycle.
REQ-011 OutValid  out  1: output entry valid.
REQ-012 OutReady  in  1: consumer accepts the entry when OutValid and OutReady are both 1.
REQ-013 OutLane  out  LANE_W: granted lane index.
REQ-014 OutPlace  out  PLACE_W: captured bit place.
REQ-015 OutProduct  out  WEIGHT_W+2^PLACE_W: weight shifted left by place (16 bits at the defaults).

Function
REQ-016 The FSM SHALL have three states: S_ARB, S_FETCH and S_OUT.
REQ-017 In S_ARB, if any LaneReadReady bit is 1, the block SHALL grant one lane by round-robin, starting the search at (last_grant+1) mod NUM_LANES.
REQ-018 On a grant, LaneReadEnable SHALL pulse for exactly one cycle on the granted lane only, and the FSM SHALL go to S_FETCH.
REQ-019 In S_ARB with no LaneReadReady bit set, LaneReadEnable SHALL be all-zero and the FSM SHALL stay in S_ARB.
REQ-020 In S_FETCH, the block SHALL register the granted lane's LaneReadData and LaneWeight, compute OutProduct = zero-extended weight << place with no truncation, set OutValid=1, and go to S_OUT.
REQ-021 In S_OUT, OutValid, OutLane, OutPlace and OutProduct SHALL stay stable until the handshake completes.
REQ-022 On the handshake cycle, OutValid SHALL go to 0 next cycle, last_grant SHALL update to the granted lane, and the FSM SHALL return to S_ARB.
REQ-023 Latency SHALL be 2 cycles from the grant cycle to OutValid=1; peak throughput SHALL be one entry per 3 cycles.
REQ-024 LaneReadEnable SHALL never assert outside S_ARB: at most one outstanding read, never to an empty lane.
REQ-025 Round-robin SHALL wrap from lane NUM_LANES-1 to lane 0.
REQ-026 Fairness: with all lanes continuously ready, every lane SHALL be granted exactly once per NUM_LANES grants.
REQ-027 LaneReadReady changes during S_FETCH or S_OUT SHALL have no effect until the FSM is next in S_ARB.

Reset
REQ-028 On RSTN=1 the FSM SHALL go to S_ARB, with LaneReadEnable=0, OutValid=0, OutLane=0, OutPlace=0, OutProduct=0, and last_grant=NUM_LANES-1 so that lane 0 has first priority.
REQ-029 Reset SHALL override any state, including S_FETCH or S_OUT mid-transaction; a popped entry that has not been delivered SHALL be discarded.

Configuration
REQ-030 With macro BIT_PLACE_SCHEDULER_STATS_EN defined, the block SHALL add output GrantCount (NUM_LANES*16) holding per-lane 16-bit counters.
REQ-031 Each counter SHALL increment on every completed handshake for its lane, wrap from 0xFFFF to 0, and clear on reset.
REQ-032 Without BIT_PLACE_SCHEDULER_STATS_EN, the GrantCount port and the counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then LaneReadReady=4'b0000 for 10 cycles -> LaneReadEnable=0, OutValid=0, state S_ARB throughout.
REQ-034 Lane 2 only ready, data place=5, weight=0x81, OutReady=1 -> LaneReadEnable=4'b0100 for one cycle; 2 cycles later OutValid=1, OutLane=2, OutPlace=5, OutProduct=0x1020.
REQ-035 All lanes ready continuously, OutReady=1, 8 grants -> lane order 0,1,2,3,0,1,2,3; grant spacing 3 cycles.
REQ-036 OutReady=0 for 5 cycles while OutValid=1 -> outputs stable, no LaneReadEnable; OutReady=1 -> OutValid=0 next cycle, next grant follows.
REQ-037 Reset asserted in S_OUT -> next cycle OutValid=0, state S_ARB, and the next grant goes to lane 0.
REQ-038 With STATS_EN: 65537 handshakes on lane 1 -> GrantCount lane 1 = 1, other lanes unchanged.
